gowin_tx_bridge: RTL and testbench
==================================

GOWIN_TX_BRIDGE -- requirements
Module: gowin_tx_bridge

Interface
REQ-001 SHALL have parameter C_PCI_DATA_WIDTH, default 256, TX datapath width in bits; only 256 is supported.
REQ-002 SHALL have ports: CLK  in  1  sole clock; RST_IN  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have RIFFA TX ports: TX_TLP in 256 data; TX_TLP_VALID in 1; TX_TLP_START_FLAG in 1; TX_TLP_START_OFFSET in 3; TX_TLP_END_FLAG in 1; TX_TLP_END_OFFSET in 3 (index of last valid DW); TX_TLP_READY out 1.
REQ-004 SHALL have Gowin TX ports: TX_ST_DATA out 256; TX_ST_VALID out 1; TX_ST_READY in 1; TX_ST_SOP out 1; TX_ST_EOP out 1; TX_ST_EMPTY out 3 (empty DWs in EOP beat).
REQ-005 SHALL have interrupt ports: INTR_MSI_REQUEST in 1; INTR_MSI_RDY out 1; APP_MSI_REQ out 1; APP_MSI_ACK in 1; TX_PROTO_ERR out 1 sticky framing error.

Function
REQ-006 SHALL transfer an input beat when TX_TLP_VALID && TX_TLP_READY, and an output beat when TX_ST_VALID && TX_ST_READY.
REQ-007 SHALL present each accepted beat on TX_ST_* exactly one cycle after acceptance when the output stage is empty (latency 1).
REQ-008 SHALL hold TX_ST_DATA/SOP/EOP/EMPTY stable while TX_ST_VALID=1 and TX_ST_READY=0.
REQ-009 SHALL drive TX_ST_SOP=TX_TLP_START_FLAG, TX_ST_EOP=TX_TLP_END_FLAG of the same beat; TX_ST_EMPTY=7-TX_TLP_END_OFFSET on EOP beats, 0 otherwise.
REQ-010 SHALL pass data unmodified, DW0 in bits [31:0].
REQ-011 SHALL track framing FSM: IDLE (no packet open) -> PKT on SOP-without-EOP beat; PKT -> IDLE on EOP beat; SOP+EOP beat stays IDLE.
REQ-012 SHALL set TX_PROTO_ERR on: SOP with nonzero START_OFFSET; SOP while in PKT; non-SOP beat while in IDLE; beats still forwarded unchanged.
REQ-013 SHALL never drop or duplicate an accepted beat under any TX_ST_READY pattern.
REQ-014 MSI FSM SHALL have states M_IDLE, M_REQ, M_HOLD; INTR_MSI_RDY=1 only in M_IDLE.
REQ-015 M_IDLE -> M_REQ when INTR_MSI_REQUEST=1; APP_MSI_REQ=1 throughout M_REQ.
REQ-016 M_REQ -> M_HOLD on APP_MSI_ACK=1 (APP_MSI_REQ deasserts next cycle); ACK in M_IDLE or M_HOLD ignored.
REQ-017 M_HOLD -> M_IDLE when INTR_MSI_REQUEST=0, so one level-held request yields exactly one MSI.

Reset
REQ-018 RST_IN=1 SHALL asynchronously force: TX_ST_VALID=0, SOP=0, EOP=0, EMPTY=0, TX_ST_DATA=0, TX_TLP_READY=0, framing FSM=IDLE, MSI FSM=M_IDLE, APP_MSI_REQ=0, INTR_MSI_RDY=0, TX_PROTO_ERR=0.
REQ-019 TX_TLP_READY and INTR_MSI_RDY SHALL assert the first cycle after RST_IN deasserts; a beat or MSI in flight at reset is discarded.

Configuration
REQ-020 Macro GOWIN_TX_SKID_EN defined: two-entry skid buffer; TX_TLP_READY is a register output, high iff fewer than two beats stored.
REQ-021 Macro undefined: single output register; TX_TLP_READY = TX_ST_READY || !TX_ST_VALID (combinational); REQ-006..013 hold identically.

Structure
REQ-022 Package riffa_gowin_pkg SHALL hold offset width (3), DW-per-beat (8), MSI state enum, framing state enum and the end-offset-to-empty function.
REQ-023 Skid/output stage SHALL be sub-module gowin_tx_skid (payload: data, SOP, EOP, EMPTY); framing and MSI FSMs in gowin_tx_bridge.

Verification
REQ-024 Single-beat TLP, SOP=EOP=1, END_OFFSET=3, READY=1 -> one beat next cycle, EMPTY=4, no error.
REQ-025 4-beat TLP, TX_ST_READY low cycles 2-4 -> 4 beats out in order, data held stable while stalled, EMPTY=7-END_OFFSET on last.
REQ-026 Random TX_ST_READY (50%), 1000 random TLPs -> scoreboard exact match, no drop/dup; both macro settings.
REQ-027 SOP with START_OFFSET=2, then SOP while PKT -> TX_PROTO_ERR=1 after first event, stays 1 until reset.
REQ-028 INTR_MSI_REQUEST held 20 cycles, ACK on cycle 5 -> APP_MSI_REQ high cycles 1-5 only, one MSI, INTR_MSI_RDY returns 1 after request drops.
REQ-029 RST_IN asserted mid-packet with TX_ST_READY=0 -> all outputs zero immediately; next TLP after reset forwarded cleanly, no error.

Source files
------------

// File: rtl/riffa_gowin_pkg.sv
// Shared types and helpers for the RIFFA-to-Gowin TX bridge.
package riffa_gowin_pkg;

  localparam int unsigned OFFSET_W    = 3;
  localparam int unsigned DW_PER_BEAT = 8;
  localparam int unsigned DATA_W      = 256;

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_HOLD} msi_state_e;

  typedef enum logic {IDLE, PKT} frame_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic                sop;
    logic                eop;
    logic [OFFSET_W-1:0] empty;
  } tx_beat_t;

  // RIFFA names the last valid DW; Gowin counts the unused DWs after it.
  function automatic logic [OFFSET_W-1:0] end_offset_to_empty(
    input logic [OFFSET_W-1:0] end_offset
  );
    return OFFSET_W'(DW_PER_BEAT - 1) - end_offset;
  endfunction

endpackage

// File: rtl/gowin_tx_skid.sv
// Output stage for the TX bridge: single register, or a two-entry skid buffer
// with a registered ready when GOWIN_TX_SKID_EN is defined.
module gowin_tx_skid
  import riffa_gowin_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sop,
  input  logic                in_eop,
  input  logic [OFFSET_W-1:0] in_empty,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic [OFFSET_W-1:0] out_empty,
  output logic                out_valid,
  input  logic                out_ready
);

  tx_beat_t in_beat;
  tx_beat_t head;

  assign in_beat   = '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty};
  assign out_data  = head.data;
  assign out_sop   = head.sop;
  assign out_eop   = head.eop;
  assign out_empty = head.empty;

`ifdef GOWIN_TX_SKID_EN
  tx_beat_t   buf0_q, buf1_q;
  logic [1:0] count_q, count_d;
  logic       ready_q;
  logic       push, pop;

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = ready_q;
  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign head      = buf0_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // buf0 is always the head; buf1 only fills while the head is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q  <= '0;
      buf1_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < 2'd2);
      if (pop) begin
        if (count_q == 2'd2) begin
          buf0_q <= buf1_q;
          if (push) buf1_q <= in_beat;
        end else if (push) begin
          buf0_q <= in_beat;
        end
      end else if (push) begin
        if (count_q == 2'd0) buf0_q <= in_beat;
        else                 buf1_q <= in_beat;
      end
    end
  end
`else
  tx_beat_t out_q;
  logic     valid_q;

  assign out_valid = valid_q;
  assign head      = out_q;
  assign in_ready  = (out_ready | ~valid_q) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) out_q <= in_beat;
    end
  end
`endif

endmodule

// File: rtl/gowin_tx_bridge.sv
// RIFFA TX to Gowin PCIe TX streaming bridge with framing check and MSI handshake.
// GOWIN_TX_SKID_EN selects the two-entry skid buffer output stage.
module gowin_tx_bridge
  import riffa_gowin_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 256
) (
  input  logic                        CLK,
  input  logic                        RST_IN,
  input  logic [C_PCI_DATA_WIDTH-1:0] TX_TLP,
  input  logic                        TX_TLP_VALID,
  input  logic                        TX_TLP_START_FLAG,
  input  logic [2:0]                  TX_TLP_START_OFFSET,
  input  logic                        TX_TLP_END_FLAG,
  input  logic [2:0]                  TX_TLP_END_OFFSET,
  output logic                        TX_TLP_READY,
  output logic [C_PCI_DATA_WIDTH-1:0] TX_ST_DATA,
  output logic                        TX_ST_VALID,
  input  logic                        TX_ST_READY,
  output logic                        TX_ST_SOP,
  output logic                        TX_ST_EOP,
  output logic [2:0]                  TX_ST_EMPTY,
  input  logic                        INTR_MSI_REQUEST,
  output logic                        INTR_MSI_RDY,
  output logic                        APP_MSI_REQ,
  input  logic                        APP_MSI_ACK,
  output logic                        TX_PROTO_ERR
);

  logic                accept;
  logic [OFFSET_W-1:0] in_empty;

  assign accept   = TX_TLP_VALID & TX_TLP_READY;
  assign in_empty = TX_TLP_END_FLAG ? end_offset_to_empty(TX_TLP_END_OFFSET) : '0;

  gowin_tx_skid u_skid (
    .clk       (CLK),
    .rst       (RST_IN),
    .in_data   (TX_TLP),
    .in_sop    (TX_TLP_START_FLAG),
    .in_eop    (TX_TLP_END_FLAG),
    .in_empty  (in_empty),
    .in_valid  (TX_TLP_VALID),
    .in_ready  (TX_TLP_READY),
    .out_data  (TX_ST_DATA),
    .out_sop   (TX_ST_SOP),
    .out_eop   (TX_ST_EOP),
    .out_empty (TX_ST_EMPTY),
    .out_valid (TX_ST_VALID),
    .out_ready (TX_ST_READY)
  );

  frame_state_e frame_q, frame_d;
  logic         err_q, err_d;

  // Framing is judged on accepted input beats; bad beats are still forwarded.
  always_comb begin
    frame_d = frame_q;
    err_d   = err_q;
    if (accept) begin
      if (TX_TLP_START_FLAG && (TX_TLP_START_OFFSET != 3'd0 || frame_q == PKT)) err_d = 1'b1;
      if (!TX_TLP_START_FLAG && frame_q == IDLE) err_d = 1'b1;
      if (TX_TLP_END_FLAG)        frame_d = IDLE;
      else if (TX_TLP_START_FLAG) frame_d = PKT;
    end
  end

  always_ff @(posedge CLK or posedge RST_IN) begin
    if (RST_IN) begin
      frame_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign TX_PROTO_ERR = err_q;

  msi_state_e msi_q, msi_d;

  always_comb begin
    msi_d = msi_q;
    unique case (msi_q)
      M_IDLE:  if (INTR_MSI_REQUEST) msi_d = M_REQ;
      M_REQ:   if (APP_MSI_ACK) msi_d = M_HOLD;
      M_HOLD:  if (!INTR_MSI_REQUEST) msi_d = M_IDLE;
      default: msi_d = M_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_IN) begin
    if (RST_IN) msi_q <= M_IDLE;
    else        msi_q <= msi_d;
  end

  assign APP_MSI_REQ  = (msi_q == M_REQ);
  assign INTR_MSI_RDY = (msi_q == M_IDLE) & ~RST_IN;

endmodule

// File: tb/tb_gowin_tx_bridge.sv
// Self-checking bench for gowin_tx_bridge: directed cases plus randomized TLP traffic.
module tb_gowin_tx_bridge;

  logic         CLK = 1'b0;
  logic         RST_IN;
  logic [255:0] TX_TLP;
  logic         TX_TLP_VALID;
  logic         TX_TLP_START_FLAG;
  logic [2:0]   TX_TLP_START_OFFSET;
  logic         TX_TLP_END_FLAG;
  logic [2:0]   TX_TLP_END_OFFSET;
  logic         TX_TLP_READY;
  logic [255:0] TX_ST_DATA;
  logic         TX_ST_VALID;
  logic         TX_ST_READY;
  logic         TX_ST_SOP;
  logic         TX_ST_EOP;
  logic [2:0]   TX_ST_EMPTY;
  logic         INTR_MSI_REQUEST;
  logic         INTR_MSI_RDY;
  logic         APP_MSI_REQ;
  logic         APP_MSI_ACK;
  logic         TX_PROTO_ERR;

  gowin_tx_bridge #(.C_PCI_DATA_WIDTH(256)) dut (
    .CLK                 (CLK),
    .RST_IN              (RST_IN),
    .TX_TLP              (TX_TLP),
    .TX_TLP_VALID        (TX_TLP_VALID),
    .TX_TLP_START_FLAG   (TX_TLP_START_FLAG),
    .TX_TLP_START_OFFSET (TX_TLP_START_OFFSET),
    .TX_TLP_END_FLAG     (TX_TLP_END_FLAG),
    .TX_TLP_END_OFFSET   (TX_TLP_END_OFFSET),
    .TX_TLP_READY        (TX_TLP_READY),
    .TX_ST_DATA          (TX_ST_DATA),
    .TX_ST_VALID         (TX_ST_VALID),
    .TX_ST_READY         (TX_ST_READY),
    .TX_ST_SOP           (TX_ST_SOP),
    .TX_ST_EOP           (TX_ST_EOP),
    .TX_ST_EMPTY         (TX_ST_EMPTY),
    .INTR_MSI_REQUEST    (INTR_MSI_REQUEST),
    .INTR_MSI_RDY        (INTR_MSI_RDY),
    .APP_MSI_REQ         (APP_MSI_REQ),
    .APP_MSI_ACK         (APP_MSI_ACK),
    .TX_PROTO_ERR        (TX_PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [255:0] d;
    logic         sop;
    logic         eop;
    logic [2:0]   so;
    logic [2:0]   eo;
  } beat_t;

  typedef struct {
    logic [255:0] d;
    logic         sop;
    logic         eop;
    logic [2:0]   empty;
  } exp_t;

  beat_t sendq[$];
  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  last_acc = 1'b0;
  logic  rand_gaps = 1'b0;
  logic  exp_err = 1'b0;
  logic  pkt_open = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Queue a TLP of len beats; start offset is always legal here.
  task automatic queue_tlp(input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = rand_data();
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      b.so  = 3'd0;
      b.eo  = 3'($urandom_range(0, 7));
      sendq.push_back(b);
    end
  endtask

  task automatic push_beat(input logic sop, input logic eop, input logic [2:0] so,
                           input logic [2:0] eo);
    beat_t b;
    b.d = rand_data(); b.sop = sop; b.eop = eop; b.so = so; b.eo = eo;
    sendq.push_back(b);
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later.
  task automatic step(input logic rdy);
    beat_t b;
    exp_t  e;
    logic  acc;
    @(negedge CLK);
    if (last_acc) void'(sendq.pop_front());
    TX_ST_READY = rdy;
    if (sendq.size() != 0) begin
      b = sendq[0];
      TX_TLP_VALID        = !rand_gaps || ($urandom_range(0, 3) != 0);
      TX_TLP              = b.d;
      TX_TLP_START_FLAG   = b.sop;
      TX_TLP_END_FLAG     = b.eop;
      TX_TLP_START_OFFSET = b.so;
      TX_TLP_END_OFFSET   = b.eo;
    end else begin
      TX_TLP_VALID = 1'b0;
    end
    #1;
    chk("st_valid", 256'(TX_ST_VALID), 256'(sb.size() != 0));
    if (sb.size() != 0 && TX_ST_VALID) begin
      e = sb[0];
      chk("st_data", TX_ST_DATA, e.d);
      chk("st_sop", 256'(TX_ST_SOP), 256'(e.sop));
      chk("st_eop", 256'(TX_ST_EOP), 256'(e.eop));
      chk("st_empty", 256'(TX_ST_EMPTY), 256'(e.empty));
    end
    chk("proto_err", 256'(TX_PROTO_ERR), 256'(exp_err));
    if (TX_ST_VALID && TX_ST_READY && sb.size() != 0) void'(sb.pop_front());
    acc = TX_TLP_VALID && TX_TLP_READY;
    if (acc) begin
      b       = sendq[0];
      e.d     = b.d;
      e.sop   = b.sop;
      e.eop   = b.eop;
      e.empty = b.eop ? 3'(7 - int'(b.eo)) : 3'd0;
      sb.push_back(e);
      if (b.sop && (b.so != 0 || pkt_open)) exp_err = 1'b1;
      if (!b.sop && !pkt_open) exp_err = 1'b1;
      pkt_open = b.eop ? 1'b0 : (b.sop ? 1'b1 : pkt_open);
    end
    last_acc = acc;
  endtask

  task automatic drain(input logic random_ready);
    int n = 0;
    while ((sendq.size() != 0 || sb.size() != 0) && n < 20000) begin
      step(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("drain_bound", 256'(n < 20000), 256'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 256'(TX_ST_VALID), 256'(0));
    chk({tag, "_data"}, TX_ST_DATA, 256'(0));
    chk({tag, "_sop"}, 256'(TX_ST_SOP), 256'(0));
    chk({tag, "_eop"}, 256'(TX_ST_EOP), 256'(0));
    chk({tag, "_empty"}, 256'(TX_ST_EMPTY), 256'(0));
    chk({tag, "_tlp_ready"}, 256'(TX_TLP_READY), 256'(0));
    chk({tag, "_msi_req"}, 256'(APP_MSI_REQ), 256'(0));
    chk({tag, "_msi_rdy"}, 256'(INTR_MSI_RDY), 256'(0));
    chk({tag, "_err"}, 256'(TX_PROTO_ERR), 256'(0));
  endtask

  task automatic apply_reset(input string tag);
    RST_IN = 1'b1;
    #1;
    check_reset_outputs(tag);
    sendq.delete();
    sb.delete();
    last_acc = 1'b0;
    exp_err  = 1'b0;
    pkt_open = 1'b0;
    TX_TLP_VALID     = 1'b0;
    INTR_MSI_REQUEST = 1'b0;
    APP_MSI_ACK      = 1'b0;
    repeat (2) @(negedge CLK);
    RST_IN = 1'b0;
    step(1'b1);
    chk({tag, "_tlp_ready_after"}, 256'(TX_TLP_READY), 256'(1));
    chk({tag, "_msi_rdy_after"}, 256'(INTR_MSI_RDY), 256'(1));
  endtask

  initial begin
    RST_IN = 1'b1;
    TX_TLP = '0; TX_TLP_VALID = 1'b0; TX_TLP_START_FLAG = 1'b0; TX_TLP_END_FLAG = 1'b0;
    TX_TLP_START_OFFSET = 3'd0; TX_TLP_END_OFFSET = 3'd0; TX_ST_READY = 1'b0;
    INTR_MSI_REQUEST = 1'b0; APP_MSI_ACK = 1'b0;
    apply_reset("por");

    // Single-beat TLP ending on DW3: EMPTY must be 4.
    push_beat(1'b1, 1'b1, 3'd0, 3'd3);
    step(1'b1);
    step(1'b1);
    chk("single_empty", 256'(TX_ST_EMPTY), 256'(4));
    drain(1'b0);

    // Four-beat TLP with the sink stalled on cycles 2-4.
    queue_tlp(4);
    for (int i = 0; i < 12; i++) step((i >= 2 && i <= 4) ? 1'b0 : 1'b1);
    drain(1'b0);
    chk("four_beat_done", 256'(sb.size()), 256'(0));

    // Random traffic under a 50% sink-ready pattern.
    rand_gaps = 1'b1;
    for (int t = 0; t < 1000; t++) queue_tlp($urandom_range(1, 4));
    drain(1'b1);
    rand_gaps = 1'b0;
    chk("random_err", 256'(TX_PROTO_ERR), 256'(0));

    // ACK while idle must not start anything.
    APP_MSI_ACK = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b1);
      chk("msi_idle_ack_req", 256'(APP_MSI_REQ), 256'(0));
      chk("msi_idle_ack_rdy", 256'(INTR_MSI_RDY), 256'(1));
    end
    APP_MSI_ACK = 1'b0;

    // Level request held 20 cycles, ACK on cycle 5: APP_MSI_REQ on cycles 1..5.
    begin
      int rises = 0;
      logic prev = 1'b0;
      for (int c = 0; c < 20; c++) begin
        step(1'b1);
        INTR_MSI_REQUEST = 1'b1;
        APP_MSI_ACK      = (c == 5);
        #1;
        chk("msi_req_window", 256'(APP_MSI_REQ), 256'(c >= 1 && c <= 5));
        chk("msi_rdy_window", 256'(INTR_MSI_RDY), 256'(c == 0));
        if (APP_MSI_REQ && !prev) rises++;
        prev = APP_MSI_REQ;
      end
      chk("msi_count", 256'(rises), 256'(1));
      step(1'b1);
      INTR_MSI_REQUEST = 1'b0;
      APP_MSI_ACK      = 1'b0;
      #1;
      chk("msi_hold_rdy", 256'(INTR_MSI_RDY), 256'(0));
      step(1'b1);
      chk("msi_rdy_return", 256'(INTR_MSI_RDY), 256'(1));
      chk("msi_req_quiet", 256'(APP_MSI_REQ), 256'(0));
    end

    // SOP with nonzero start offset, then SOP while a packet is open.
    push_beat(1'b1, 1'b1, 3'd2, 3'd7);
    push_beat(1'b1, 1'b0, 3'd0, 3'd0);
    push_beat(1'b1, 1'b0, 3'd0, 3'd0);
    push_beat(1'b0, 1'b1, 3'd0, 3'd5);
    drain(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("err_sticky", 256'(TX_PROTO_ERR), 256'(1));
    apply_reset("err_clear");

    // Reset in the middle of a stalled packet.
    queue_tlp(3);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    apply_reset("mid_pkt");
    queue_tlp(2);
    drain(1'b1);
    chk("post_reset_err", 256'(TX_PROTO_ERR), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
